// File: rtl/slot_pkg.sv
// +--------------------------------------------------------------------------+
// | slot_pkg : shared symbol, state and result definitions for the reels      |
// | Revision : 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

package slot_pkg;

  localparam int SYM_W = 3;
  localparam logic [SYM_W-1:0] BLANK = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SPIN  = 2'd1,
    JUDGE = 2'd2,
    SHOW  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    LOSE    = 2'b00,
    PAIR    = 2'b01,
    TRIPLE  = 2'b10,
    JACKPOT = 2'b11
  } result_e;

  function automatic result_e judge(input logic [SYM_W-1:0] a,
                                    input logic [SYM_W-1:0] b,
                                    input logic [SYM_W-1:0] c,
                                    input logic [SYM_W-1:0] top);
    if (a == b && b == c) begin
      return (a == top) ? JACKPOT : TRIPLE;
    end else if (a == b || b == c || a == c) begin
      return PAIR;
    end
    return LOSE;
  endfunction

endpackage

`default_nettype wire

// File: rtl/slot_reel.sv
// +--------------------------------------------------------------------------+
// | slot_reel : one reel - wrapping symbol counter with running flag          |
// | Revision  : 1.0                                                           |
// +--------------------------------------------------------------------------+
`default_nettype none

module slot_reel
  import slot_pkg::*;
#(
  parameter int NUM_SYMBOLS = 7
) (
  input  logic             clock,
  input  logic             resetN,
  input  logic             tick,
  input  logic             start,
  input  logic             stop,
  input  logic             force_stop,
  output logic [SYM_W-1:0] symbol,
  output logic             running
);

  localparam logic [SYM_W-1:0] c_top = SYM_W'(NUM_SYMBOLS - 1);

  logic [SYM_W-1:0] symbol_q, symbol_d;
  logic             running_q, running_d;

  // A stop (button or forced) beats a coincident tick: the reel freezes pre-tick.
  always_comb begin
    symbol_d  = symbol_q;
    running_d = running_q;
    if (start) begin
      running_d = 1'b1;
    end else if (running_q) begin
      if (stop || force_stop) begin
        running_d = 1'b0;
      end else if (tick) begin
        symbol_d = (symbol_q >= c_top) ? '0 : symbol_q + SYM_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!resetN) begin
      symbol_q  <= '0;
      running_q <= 1'b0;
    end else begin
      symbol_q  <= symbol_d;
      running_q <= running_d;
    end
  end

  assign symbol  = (symbol_q == BLANK) ? '0 : symbol_q;
  assign running = running_q;

endmodule

`default_nettype wire

// File: rtl/slot_reel_controller.sv
// +--------------------------------------------------------------------------+
// | slot_reel_controller : three-reel slot machine sequencer and judge        |
// | Optional forced stop after AUTOSTOP_TICKS ticks: define SLOT_AUTOSTOP_EN  |
// | Revision : 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module slot_reel_controller
  import slot_pkg::*;
#(
  parameter int NUM_SYMBOLS    = 7,
  parameter int AUTOSTOP_TICKS = 200
) (
  input  logic             clock,
  input  logic             resetN,
  input  logic             reelTick,
  input  logic             startBtn,
  input  logic [2:0]       stopBtn,
  output logic [SYM_W-1:0] left,
  output logic [SYM_W-1:0] middle,
  output logic [SYM_W-1:0] right,
  output logic [2:0]       running,
  output logic [1:0]       result,
  output logic             resultValid,
  output logic             busy
);

  if (NUM_SYMBOLS < 2 || NUM_SYMBOLS > 7 || AUTOSTOP_TICKS < 1) begin : g_param_check
    $error("slot_reel_controller: illegal parameter value");
  end

  state_e     state_q, state_d;
  result_e    result_q, result_d;
  logic       valid_q, valid_d;
  logic       busy_q, busy_d;
  logic [3:0] btn_prev_q, btn_prev_d;
  logic [3:0] arm_q, arm_d;

  logic [3:0]       w_btn_now;
  logic [3:0]       w_btn_edge;
  logic             w_spin_start;
  logic [2:0]       w_stop;
  logic             w_force_stop;
  logic [SYM_W-1:0] w_sym [3];
  logic [2:0]       w_run;

  // arm_q blocks any button still held from reset until it has been seen low.
  assign w_btn_now    = {startBtn, stopBtn};
  assign w_btn_edge   = w_btn_now & ~btn_prev_q & arm_q;
  assign w_spin_start = w_btn_edge[3] && (state_q == IDLE || state_q == SHOW);
  assign w_stop       = w_btn_edge[2:0] & {3{state_q == SPIN}};
  assign btn_prev_d   = w_btn_now;
  assign arm_d        = arm_q | ~w_btn_now;

`ifdef SLOT_AUTOSTOP_EN
  localparam int c_cnt_w = $clog2(AUTOSTOP_TICKS + 1);

  logic [c_cnt_w-1:0] tick_cnt_q, tick_cnt_d;

  // The tick that would reach the limit stops the reels instead of advancing them.
  assign w_force_stop = (state_q == SPIN) && reelTick &&
                        (tick_cnt_q == c_cnt_w'(AUTOSTOP_TICKS - 1));

  always_comb begin
    tick_cnt_d = tick_cnt_q;
    if (w_spin_start) begin
      tick_cnt_d = '0;
    end else if (state_q == SPIN && reelTick &&
                 tick_cnt_q < c_cnt_w'(AUTOSTOP_TICKS)) begin
      tick_cnt_d = tick_cnt_q + c_cnt_w'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!resetN) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
    end
  end
`else
  assign w_force_stop = 1'b0;
`endif

  for (genvar i = 0; i < 3; i++) begin : g_reel
    slot_reel #(
      .NUM_SYMBOLS (NUM_SYMBOLS)
    ) u_reel (
      .clock      (clock),
      .resetN     (resetN),
      .tick       (reelTick),
      .start      (w_spin_start),
      .stop       (w_stop[i]),
      .force_stop (w_force_stop),
      .symbol     (w_sym[i]),
      .running    (w_run[i])
    );
  end

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    case (state_q)
      IDLE, SHOW: begin
        if (w_spin_start) begin
          state_d  = SPIN;
          result_d = LOSE;
        end
      end
      SPIN: begin
        if (w_run == 3'b000) begin
          state_d = JUDGE;
        end
      end
      JUDGE: begin
        state_d  = SHOW;
        result_d = judge(w_sym[2], w_sym[1], w_sym[0], SYM_W'(NUM_SYMBOLS - 1));
      end
      default: state_d = IDLE;
    endcase
    valid_d = (state_d == SHOW);
    busy_d  = (state_d == SPIN) || (state_d == JUDGE);
  end

  always_ff @(posedge clock) begin
    if (!resetN) begin
      state_q    <= IDLE;
      result_q   <= LOSE;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      btn_prev_q <= '0;
      arm_q      <= '0;
    end else begin
      state_q    <= state_d;
      result_q   <= result_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      btn_prev_q <= btn_prev_d;
      arm_q      <= arm_d;
    end
  end

  assign left        = w_sym[2];
  assign middle      = w_sym[1];
  assign right       = w_sym[0];
  assign running     = w_run;
  assign result      = result_q;
  assign resultValid = valid_q;
  assign busy        = busy_q;

endmodule

`default_nettype wire
